// File: rtl/if_fetch_queue.sv
// In-order instruction-fetch queue: issues sequential fetches, buffers responses
// against their PCs, presents the head to decode and flushes on a MEM-stage redirect.
module if_fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP      = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [XLEN-1:0] inst_pc_plus_4_o
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             OW      = $clog2(DEPTH + 1);
    localparam logic [OW-1:0]  DEPTH_O = OW'(DEPTH);
    localparam logic [PW-1:0]  LAST_P  = PW'(DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]    alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
    logic [OW-1:0]    occ_q, occ_d, drop_q, drop_d;
    logic [DEPTH-1:0] filled_q;
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic             req_fire, rsp_keep, rsp_drop, head_valid, deq;
    logic [OW-1:0]    n_filled, outstanding, drop_redir;

    always_comb begin
        n_filled = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n_filled = n_filled + OW'(filled_q[i]);
        end
    end

    assign imem_req_valid_o = !reset_i && !redirect_valid_i && (occ_q < DEPTH_O);
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_drop         = imem_rsp_valid_i && (drop_q != '0);
    assign rsp_keep         = imem_rsp_valid_i && (drop_q == '0);
    assign head_valid       = filled_q[head_q] && !reset_i;
    assign deq              = head_valid && inst_ready_i;

    // Unfilled allocated entries are exactly the requests still owed a response.
    assign outstanding = occ_q - n_filled;
    assign drop_redir  = outstanding - OW'(rsp_keep) + (rsp_drop ? drop_q - OW'(1) : drop_q);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        head_d     = head_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            alloc_d    = '0;
            fill_d     = '0;
            head_d     = '0;
            occ_d      = '0;
            drop_d     = drop_redir;
        end else begin
            if (req_fire) begin
                alloc_d    = ptr_inc(alloc_q);
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_drop) drop_d = drop_q - OW'(1);
            if (rsp_keep) fill_d = ptr_inc(fill_q);
            if (deq)      head_d = ptr_inc(head_q);
            occ_d = occ_q + OW'(req_fire) - OW'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            alloc_q    <= '0;
            fill_q     <= '0;
            head_q     <= '0;
            occ_q      <= '0;
            drop_q     <= '0;
            filled_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            head_q     <= head_d;
            occ_q      <= occ_d;
            drop_q     <= drop_d;
            if (redirect_valid_i) begin
                filled_q <= '0;
            end else begin
                if (req_fire) filled_q[alloc_q] <= 1'b0;
                if (rsp_keep) filled_q[fill_q]  <= 1'b1;
                if (deq)      filled_q[head_q]  <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset; the filled bits qualify it.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !redirect_valid_i) begin
            if (req_fire) pc_q[alloc_q]  <= fetch_pc_q;
            if (rsp_keep) data_q[fill_q] <= imem_rsp_data_i;
        end
    end

    assign inst_valid_o     = head_valid;
    assign inst_o           = head_valid ? data_q[head_q] : NOP;
    assign inst_pc_o        = head_valid ? pc_q[head_q] : '0;
    assign inst_pc_plus_4_o = head_valid ? pc_q[head_q] + XLEN'(4) : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: vector table, directed redirect/reset sequences and
// random traffic checked against a queue-based reference model and a latency memory.
module tb_if_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, req_ready, rsp_valid, inst_ready;
    logic [31:0] redirect_pc, rsp_data;
    logic        req_valid_o, inst_valid_o;
    logic [31:0] req_addr_o, inst_o, inst_pc_o, inst_pc4_o;

    always #5 clk = ~clk;

    if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC), .NOP(NOP)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (req_valid_o),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr_o),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_pc_plus_4_o (inst_pc4_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        bit rst; bit irdy; bit qrdy;
        bit rv; logic [31:0] addr; bit iv; logic [31:0] ipc;
    } vec_t;

    ent_t        mq[$];
    mreq_t       memq[$];
    vec_t        tbl[$];
    logic [31:0] m_fetch = RPC;
    int          m_drop  = 0;
    bit          exp_rv, exp_iv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic add(input bit rst, input bit irdy, input bit qrdy, input bit rv,
                       input logic [31:0] addr, input bit iv, input logic [31:0] ipc);
        tbl.push_back(vec_t'{rst: rst, irdy: irdy, qrdy: qrdy, rv: rv, addr: addr, iv: iv, ipc: ipc});
    endtask

    // Memory drives its response, then outputs are compared with the model.
    task automatic begin_cycle();
        ent_t h;
        if (!reset && memq.size() > 0 && memq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = memf(memq[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
        end
        #1;
        exp_rv = !reset && !redirect_valid && (mq.size() < DEPTH);
        exp_iv = !reset && (mq.size() > 0) && mq[0].filled;
        h = '{pc: 32'h0, data: 32'h0, filled: 1'b0};
        if (mq.size() > 0) h = mq[0];
        chk("req_valid", 32'(req_valid_o), 32'(exp_rv));
        if (exp_rv) chk("req_addr", req_addr_o, m_fetch);
        chk("inst_valid", 32'(inst_valid_o), 32'(exp_iv));
        chk("inst", inst_o, exp_iv ? h.data : NOP);
        chk("inst_pc", inst_pc_o, exp_iv ? h.pc : 32'h0);
        chk("inst_pc_plus_4", inst_pc4_o, exp_iv ? h.pc + 32'd4 : 32'h0);
    endtask

    task automatic end_cycle();
        bit   deq, acc_dut;
        int   outst, idx;
        ent_t tmp;
        acc_dut = req_valid_o && req_ready;
        if (reset) memq.delete();
        else begin
            if (rsp_valid) void'(memq.pop_front());
            if (acc_dut) memq.push_back(mreq_t'{addr: req_addr_o, due: cyc + lat});
        end
        if (reset) begin
            mq.delete();
            m_fetch = RPC;
            m_drop  = 0;
        end else if (redirect_valid) begin
            outst = 0;
            foreach (mq[i]) if (!mq[i].filled) outst++;
            if (rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else outst--;
            end
            m_drop  = m_drop + outst;
            mq.delete();
            m_fetch = redirect_pc;
        end else begin
            deq = exp_iv && inst_ready;
            if (rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    idx = -1;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            idx = i;
                            break;
                        end
                    end
                    chk("rsp_has_alloc", 32'(idx >= 0), 32'd1);
                    if (idx >= 0) begin
                        tmp = mq[idx];
                        tmp.filled = 1'b1;
                        tmp.data   = rsp_data;
                        mq[idx] = tmp;
                    end
                end
            end
            if (deq) void'(mq.pop_front());
            if (exp_rv && req_ready) begin
                mq.push_back(ent_t'{pc: m_fetch, data: 32'h0, filled: 1'b0});
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        begin_cycle();
        end_cycle();
    endtask

    task automatic run_reset(input int n);
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic wait_inst(input string name, input logic [31:0] pc, input int n_exp);
        bit seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            begin_cycle();
            if (inst_valid_o) begin
                seen = 1'b1;
                chk({name, "_first_pc"}, inst_pc_o, pc);
                chk({name, "_first_wait"}, 32'(n), 32'(n_exp));
            end
            end_cycle();
        end
        chk({name, "_first_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        req_ready = 1'b0; inst_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;

        // Streaming from reset, then back-pressure fill and release, 1-cycle memory.
        add(1, 1, 1, 0, 32'h0,   0, 32'h0);
        add(1, 1, 1, 0, 32'h0,   0, 32'h0);
        add(0, 1, 1, 1, 32'h100, 0, 32'h0);
        add(0, 1, 1, 1, 32'h104, 0, 32'h0);
        add(0, 1, 1, 1, 32'h108, 1, 32'h100);
        add(0, 1, 1, 1, 32'h10C, 1, 32'h104);
        add(0, 1, 1, 1, 32'h110, 1, 32'h108);
        add(0, 1, 1, 1, 32'h114, 1, 32'h10C);
        add(1, 0, 1, 0, 32'h0,   0, 32'h0);
        add(1, 0, 1, 0, 32'h0,   0, 32'h0);
        add(0, 0, 1, 1, 32'h100, 0, 32'h0);
        add(0, 0, 1, 1, 32'h104, 0, 32'h0);
        add(0, 0, 1, 1, 32'h108, 1, 32'h100);
        add(0, 0, 1, 1, 32'h10C, 1, 32'h100);
        add(0, 0, 1, 0, 32'h0,   1, 32'h100);
        add(0, 0, 1, 0, 32'h0,   1, 32'h100);
        add(0, 1, 1, 0, 32'h0,   1, 32'h100);
        add(0, 1, 1, 1, 32'h110, 1, 32'h104);
        add(0, 1, 1, 1, 32'h114, 1, 32'h108);
        add(0, 1, 1, 1, 32'h118, 1, 32'h10C);
        add(0, 1, 1, 1, 32'h11C, 1, 32'h110);

        @(negedge clk);
        lat = 1;
        foreach (tbl[k]) begin
            reset      = tbl[k].rst;
            inst_ready = tbl[k].irdy;
            req_ready  = tbl[k].qrdy;
            begin_cycle();
            chk("tv_req_valid", 32'(req_valid_o), 32'(tbl[k].rv));
            if (tbl[k].rv) chk("tv_req_addr", req_addr_o, tbl[k].addr);
            chk("tv_inst_valid", 32'(inst_valid_o), 32'(tbl[k].iv));
            chk("tv_inst_pc", inst_pc_o, tbl[k].iv ? tbl[k].ipc : 32'h0);
            chk("tv_inst", inst_o, tbl[k].iv ? memf(tbl[k].ipc) : NOP);
            end_cycle();
        end

        // Redirect with three requests in flight and none answered yet.
        lat = 4;
        run_reset(2);
        req_ready = 1'b1; inst_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h2000;
        begin_cycle();
        chk("c_req_blocked", 32'(req_valid_o), 32'd0);
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        chk("c_req_valid", 32'(req_valid_o), 32'd1);
        chk("c_req_addr", req_addr_o, 32'h2000);
        end_cycle();
        wait_inst("c", 32'h2000, 4);

        // Redirect coinciding with a response that would otherwise be kept.
        lat = 2;
        run_reset(2);
        req_ready = 1'b1; inst_ready = 1'b1;
        repeat (2) step();
        redirect_valid = 1'b1; redirect_pc = 32'h2000;
        begin_cycle();
        chk("d_rsp_present", 32'(rsp_valid), 32'd1);
        chk("d_req_blocked", 32'(req_valid_o), 32'd0);
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        chk("d_req_valid", 32'(req_valid_o), 32'd1);
        chk("d_req_addr", req_addr_o, 32'h2000);
        end_cycle();
        wait_inst("d", 32'h2000, 2);

        // One-cycle reset with the queue full of returned instructions.
        lat = 1;
        run_reset(2);
        req_ready = 1'b1; inst_ready = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        begin_cycle();
        chk("e_rst_req_valid", 32'(req_valid_o), 32'd0);
        chk("e_rst_inst_valid", 32'(inst_valid_o), 32'd0);
        end_cycle();
        reset = 1'b0;
        begin_cycle();
        chk("e_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("e_req_valid", 32'(req_valid_o), 32'd1);
        chk("e_req_addr", req_addr_o, RPC);
        end_cycle();

        // Random traffic; redirects only while the memory holds at most DEPTH beats.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(1, 4);
            reset          = ($urandom_range(0, 299) == 0);
            redirect_valid = !reset && ($urandom_range(0, 24) == 0) && (memq.size() <= DEPTH);
            redirect_pc    = $urandom_range(0, 16383) << 2;
            req_ready      = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
